piso_tx: RTL

//   Parallel-in serial-out transmitter: accepts an N-bit word over a

---
 rtl/piso_tx.sv | 109 ++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word over a valid/ready load
// handshake and shifts it out one bit per clock, with gapless back-to-back words.
module piso_tx #(
  parameter int N          = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] parallel_in_i,
  input  logic         load_valid_i,
  output logic         load_ready_o,
  output logic         serial_out_o,
  output logic         serial_valid_o,
  output logic         frame_start_o,
  output logic         frame_last_o,
  output logic         busy_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST   = CW'(N - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(N - 2);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic          serial_out_q, serial_out_d;
  logic          serial_valid_q, serial_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_last_q, frame_last_d;
  logic          accept;

  function automatic logic lead_bit(input logic [N-1:0] w);
    return MSB_FIRST ? w[N-1] : w[0];
  endfunction

  function automatic logic [N-1:0] shift_word(input logic [N-1:0] w);
    return MSB_FIRST ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
  endfunction

  // Ready while idle, or while the last bit of the current word is on the line.
  assign load_ready_o = !reset_i &&
                        ((state_q == ST_IDLE) ||
                         ((state_q == ST_SHIFT) && (cnt_q == CNT_LAST)));
  assign accept = load_valid_i && load_ready_o;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
    serial_out_d   = serial_out_q;
    serial_valid_d = serial_valid_q;
    frame_start_d  = 1'b0;
    frame_last_d   = 1'b0;
    if (accept) begin
      // First bit goes straight to the output; the register keeps the rest.
      state_d        = ST_SHIFT;
      cnt_d          = '0;
      serial_out_d   = lead_bit(parallel_in_i);
      shreg_d        = shift_word(parallel_in_i);
      serial_valid_d = 1'b1;
      frame_start_d  = 1'b1;
    end else if (state_q == ST_SHIFT) begin
      if (cnt_q == CNT_LAST) begin
        state_d        = ST_IDLE;
        cnt_d          = '0;
        shreg_d        = '0;
        serial_out_d   = IDLE_LEVEL;
        serial_valid_d = 1'b0;
      end else begin
        cnt_d          = CW'(cnt_q + 1'b1);
        serial_out_d   = lead_bit(shreg_q);
        shreg_d        = shift_word(shreg_q);
        serial_valid_d = 1'b1;
        frame_last_d   = (cnt_q == CNT_PENULT);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      shreg_q        <= '0;
      serial_out_q   <= IDLE_LEVEL;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_last_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      frame_start_q  <= frame_start_d;
      frame_last_q   <= frame_last_d;
    end
  end

  assign serial_out_o   = serial_out_q;
  assign serial_valid_o = serial_valid_q;
  assign frame_start_o  = frame_start_q;
  assign frame_last_o   = frame_last_q;
  assign busy_o         = serial_valid_q;

endmodule
